// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the seven-segment scan driver: segment
//                bit positions, active-high hex glyph patterns and the
//                counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Bit positions inside the 7-bit segment vector (a is the MSB).
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high glyphs, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] HEX_0 = 7'b1111110;  // abcdef
    localparam logic [6:0] HEX_1 = 7'b0110000;  // bc
    localparam logic [6:0] HEX_2 = 7'b1101101;  // abdeg
    localparam logic [6:0] HEX_3 = 7'b1111001;  // abcdg
    localparam logic [6:0] HEX_4 = 7'b0110011;  // bcfg
    localparam logic [6:0] HEX_5 = 7'b1011011;  // acdfg
    localparam logic [6:0] HEX_6 = 7'b1011111;  // acdefg
    localparam logic [6:0] HEX_7 = 7'b1110000;  // abc
    localparam logic [6:0] HEX_8 = 7'b1111111;  // abcdefg
    localparam logic [6:0] HEX_9 = 7'b1111011;  // abcdfg
    localparam logic [6:0] HEX_A = 7'b1110111;  // abcefg
    localparam logic [6:0] HEX_B = 7'b0011111;  // cdefg
    localparam logic [6:0] HEX_C = 7'b1001110;  // adef
    localparam logic [6:0] HEX_D = 7'b0111101;  // bcdeg
    localparam logic [6:0] HEX_E = 7'b1001111;  // adefg
    localparam logic [6:0] HEX_F = 7'b1000111;  // aefg

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to active-high segment pattern.
//                Polarity and blanking are handled by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    // Table lookup of the glyph for the incoming nibble.
    always_comb begin
        pattern = HEX_0;
        case (value)
            4'h0: pattern = HEX_0;
            4'h1: pattern = HEX_1;
            4'h2: pattern = HEX_2;
            4'h3: pattern = HEX_3;
            4'h4: pattern = HEX_4;
            4'h5: pattern = HEX_5;
            4'h6: pattern = HEX_6;
            4'h7: pattern = HEX_7;
            4'h8: pattern = HEX_8;
            4'h9: pattern = HEX_9;
            4'hA: pattern = HEX_A;
            4'hB: pattern = HEX_B;
            4'hC: pattern = HEX_C;
            4'hD: pattern = HEX_D;
            4'hE: pattern = HEX_E;
            4'hF: pattern = HEX_F;
            default: pattern = HEX_0;
        endcase
    end

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : N-digit multiplexed seven-segment driver with per-digit
//                blanking and decimal points, anode dead-time and a
//                double-buffered (pending/shadow) display image that only
//                changes on frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int CNT_W = cnt_width(SLOT_CYCLES);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Electrical level for a dark / lit anode or segment.
    localparam logic C_DARK = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic C_LIT  = ~C_DARK;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_anode_on;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic [6:0]              w_pattern;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;

    assign w_slot_end  = (r_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);

    // With no dead time the anode is lit for the whole slot; otherwise only
    // once the slot counter has passed the blanking window.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign w_anode_on = 1'b1;
        end else begin : g_dead
            localparam logic [CNT_W-1:0] C_CNT_DEAD = CNT_W'(DEAD_CYCLES);
            assign w_anode_on = (r_cnt >= C_CNT_DEAD);
        end
    endgenerate

    // Slot counter and digit index; index advances at the end of every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending captures every load; shadow takes pending at each frame
    // boundary, bypassing pending when the load coincides with the boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_blank    <= '0;
        end else begin
            if (load) begin
                r_pend_digits <= digits;
                r_pend_dp     <= dp_in;
                r_pend_blank  <= blank;
            end
            if (w_frame_end) begin
                r_sh_digits <= load ? digits : r_pend_digits;
                r_sh_dp     <= load ? dp_in  : r_pend_dp;
                r_sh_blank  <= load ? blank  : r_pend_blank;
            end
        end
    end

    // Select the shadow entry for the digit currently being scanned.
    always_comb begin
        w_cur_digit = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit = r_sh_digits[4*i +: 4];
                w_cur_dp    = r_sh_dp[i];
                w_cur_blank = r_sh_blank[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .value   (w_cur_digit),
        .pattern (w_pattern)
    );

    // Next output levels: one anode at most, blanking overrides the glyph.
    always_comb begin
        w_an_next = {NUM_DIGITS{C_DARK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((r_idx == IDX_W'(i)) && w_anode_on) begin
                w_an_next[i] = C_LIT;
            end
        end
        if (w_cur_blank) begin
            w_seg_next = {7{C_DARK}};
            w_dp_next  = C_DARK;
        end else begin
            w_seg_next = w_pattern ^ {7{C_DARK}};
            w_dp_next  = w_cur_dp ? C_LIT : C_DARK;
        end
    end

    // Output registers keep the board pins glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= {NUM_DIGITS{C_DARK}};
            r_seg        <= {7{C_DARK}};
            r_dp         <= C_DARK;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_frame_tick <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule : seven_seg_scan_driver
`default_nettype wire
